nibble_add_sequencer: RTL

Multi-cycle controller that performs N-nibble add/subtract on wide operands by time-multiplexing one external 4-bit ripple adder (ports A, B, C0 → F, C4). It latches operands on a start request and feeds the adder one nibble per cycle, least significant nibble first. It chains the carry through an internal register and returns the full-width result, carry-out and signed overflow behind a start/busy/done handshake. It sits between the experiment's operand source (switches/test logic) and the shared 4-bit adder instance.

---
 rtl/nibble_add_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/nibble_add_sequencer.sv
// -----------------------------------------------------------------------------
// nibble_add_sequencer
//
// Performs a W-bit add or subtract (W = 4*NIBBLES) by time-multiplexing one
// external 4-bit ripple adder. On an accepted start the operands are latched
// and one nibble is fed to the adder per cycle, least significant first. The
// carry is chained through an internal register. The full result, carry-out
// and signed overflow are returned behind a start/busy/done handshake.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           operation request, sampled only in IDLE or DONE
//   sub             0: op_a + op_b + cin, 1: op_a - op_b (cin ignored)
//   cin             carry-in for add
//   op_a, op_b      W-bit operands
//   busy            high while nibbles are being processed
//   done            one-cycle pulse when result/cout/overflow become valid
//   result          W-bit sum or difference
//   cout            final carry-out (for subtract: 1 = no borrow)
//   overflow        signed overflow of the W-bit operation
//   add_a/b/c0      drive the external 4-bit adder (zero outside RUN)
//   add_f, add_c4   sum nibble and carry returned by the external adder
// -----------------------------------------------------------------------------
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_c0,
  input  logic [3:0]             add_f,
  input  logic                   add_c4
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q,    state_d;
  logic [IDXW-1:0]   idx_q,      idx_d;
  logic [W-1:0]      opa_q,      opa_d;
  logic [W-1:0]      opb_q,      opb_d;
  logic              carry_q,    carry_d;
  logic [W-1:0]      acc_q,      acc_d;
  logic [W-1:0]      result_q,   result_d;
  logic              cout_q,     cout_d;
  logic              overflow_q, overflow_d;

  logic              accept;
  logic              last_nib;
  logic [IDXW+1:0]   nib_lsb;

  // A start is only honoured when no operation is in flight; DONE counts as
  // free so that a held start chains operations without an IDLE gap.
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_nib = (state_q == RUN) && (idx_q == LAST_IDX);
  assign nib_lsb  = {idx_q, 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The adder is fed straight from registers so the whole
  // register -> adder -> register path fits in one cycle.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    add_a  = 4'h0;
    add_b  = 4'h0;
    add_c0 = 1'b0;
    case (state_q)
      RUN: begin
        busy   = 1'b1;
        add_a  = opa_q[nib_lsb +: 4];
        add_b  = opb_q[nib_lsb +: 4];
        add_c0 = carry_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state. Subtraction is done as a + ~b + 1, so the operand
  // is inverted at latch time and the initial carry forced to 1. The final
  // nibble lands in the top of the accumulator, so the updated accumulator is
  // the complete result on the last cycle.
  always_comb begin
    idx_d      = idx_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    if (accept) begin
      opa_d   = op_a;
      opb_d   = sub ? ~op_b : op_b;
      carry_d = sub ? 1'b1 : cin;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      acc_d[nib_lsb +: 4] = add_f;
      carry_d             = add_c4;
      if (last_nib) begin
        idx_d      = '0;
        result_d   = acc_d;
        cout_d     = add_c4;
        // Carry into the MSB (a^b^f at bit 3) differs from carry out of it.
        overflow_d = add_c4 ^ (add_a[3] ^ add_b[3] ^ add_f[3]);
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      carry_q    <= carry_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule
